// File: rtl/matrix_scan_controller.sv
// Column-scan sequencer for a multiplexed LED matrix.
// Blanks between columns and double-buffers frames at frame boundaries.
module matrix_scan_controller #(
  parameter int N_COLS       = 5,
  parameter int N_ROWS       = 7,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 4,
  parameter int CW           = $clog2(N_COLS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_COLS*N_ROWS-1:0] frame_data,
  input  logic                     frame_valid,
  output logic                     frame_ready,
  output logic [N_COLS-1:0]        col_sel,
  output logic [N_ROWS-1:0]        row_out,
  output logic [CW-1:0]            col_idx,
  output logic                     frame_done
);

  localparam int TMAX = (DWELL_CYCLES > BLANK_CYCLES) ?
                        DWELL_CYCLES : BLANK_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int FW = N_COLS * N_ROWS;
  localparam logic [TW-1:0] BLANK_LD = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] DWELL_LD = TW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(N_COLS - 1);
  localparam logic [N_COLS-1:0] ONE_HOT0 = N_COLS'(1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  state_t              r_state, w_state_nx;
  logic [TW-1:0]       r_timer, w_timer_nx;
  logic [CW-1:0]       r_col, w_col_nx;
  logic [N_COLS-1:0]   r_sel, w_sel_nx;
  logic [N_ROWS-1:0]   r_row, w_row_nx;
  logic                r_done, w_done_nx;
  logic [FW-1:0]       r_active;
  logic [FW-1:0]       r_shadow;
  logic                r_full;
  logic                w_swap;
  logic                w_load;

  assign w_load = frame_valid && !r_full;

  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer;
    w_col_nx   = r_col;
    w_sel_nx   = r_sel;
    w_row_nx   = r_row;
    w_done_nx  = 1'b0;
    w_swap     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_sel_nx = '1;
        w_row_nx = '0;
        w_col_nx = '0;
        if (enable) begin
          w_swap     = r_full;
          w_state_nx = BLANK;
          w_timer_nx = BLANK_LD;
        end
      end
      BLANK: begin
        if (r_timer == '0) begin
          w_state_nx = SHOW;
          w_timer_nx = DWELL_LD;
          w_sel_nx   = ~(ONE_HOT0 << r_col);
          w_row_nx   = r_active[r_col*N_ROWS +: N_ROWS];
        end else begin
          w_timer_nx = r_timer - TW'(1);
        end
      end
      SHOW: begin
        if (r_timer == '0) begin
          w_sel_nx = '1;
          w_row_nx = '0;
          if (!enable) begin
            w_state_nx = IDLE;
            w_col_nx   = '0;
          end else begin
            w_state_nx = BLANK;
            w_timer_nx = BLANK_LD;
            if (r_col == LAST_COL) begin
              // Wrap point: the only mid-run place new data may appear
              w_col_nx  = '0;
              w_done_nx = 1'b1;
              w_swap    = r_full;
            end else begin
              w_col_nx = r_col + CW'(1);
            end
          end
        end else begin
          w_timer_nx = r_timer - TW'(1);
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_sel_nx   = '1;
        w_row_nx   = '0;
        w_col_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_col   <= '0;
      r_sel   <= '1;
      r_row   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_timer <= w_timer_nx;
      r_col   <= w_col_nx;
      r_sel   <= w_sel_nx;
      r_row   <= w_row_nx;
      r_done  <= w_done_nx;
    end
  end

  // Swap needs r_full=1 and load needs r_full=0, so they never collide
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_active <= '0;
      r_shadow <= '0;
      r_full   <= 1'b0;
    end else if (w_swap) begin
      r_active <= r_shadow;
      r_full   <= 1'b0;
    end else if (w_load) begin
      r_shadow <= frame_data;
      r_full   <= 1'b1;
    end
  end

  assign frame_ready = ~r_full;
  assign col_sel     = r_sel;
  assign row_out     = r_row;
  assign col_idx     = r_col;
  assign frame_done  = r_done;

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Directed bench for matrix_scan_controller.
// Small parameters: 5 columns, 7 rows, dwell 3, blank 2.
module tb_matrix_scan_controller;

  localparam int NC = 5;
  localparam int NR = 7;
  localparam int DW = 3;
  localparam int BL = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic [NC*NR-1:0] frame_data = '0;
  logic             frame_valid = 1'b0;
  logic             frame_ready;
  logic [NC-1:0]    col_sel;
  logic [NR-1:0]    row_out;
  logic [2:0]       col_idx;
  logic             frame_done;

  int errors = 0;
  int checks = 0;
  int k = 0;

  logic [NC*NR-1:0] fa, fb, fc, fd;

  always #5 clock = ~clock;

  matrix_scan_controller #(
    .N_COLS(NC),
    .N_ROWS(NR),
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .frame_data(frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .col_sel(col_sel),
    .row_out(row_out),
    .col_idx(col_idx),
    .frame_done(frame_done)
  );

  // k counts edges since enable was sampled in IDLE; one column = 5 cycles
  task automatic tick();
    @(posedge clock);
    #1;
    k++;
  endtask

  function automatic logic [4:0] e_sel(input int kk);
    int p = kk % 5;
    int c = (kk / 5) % 5;
    logic [4:0] one = 5'b00001;
    return (p >= 2) ? ~(one << c) : 5'b11111;
  endfunction

  function automatic logic [6:0] e_row(input int kk,
                                       input logic [34:0] f);
    int p = kk % 5;
    int c = (kk / 5) % 5;
    return (p >= 2) ? f[c*7 +: 7] : 7'h00;
  endfunction

  function automatic logic [2:0] e_col(input int kk);
    return 3'((kk / 5) % 5);
  endfunction

  function automatic logic e_done(input int kk);
    return (kk > 0) && (kk % 25 == 0);
  endfunction

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    checks++;
    if (col_sel !== 5'b11111) begin
      errors++;
      $display("FAIL rst_col_sel got=%b exp=11111", col_sel);
    end
    checks++;
    if (row_out !== 7'h00) begin
      errors++;
      $display("FAIL rst_row_out got=%h exp=00", row_out);
    end
    checks++;
    if (col_idx !== 3'd0) begin
      errors++;
      $display("FAIL rst_col_idx got=%0d exp=0", col_idx);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_frame_done got=%b exp=0", frame_done);
    end
    checks++;
    if (frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_frame_ready got=%b exp=1", frame_ready);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_load_run();
    tick();
    frame_data  = fa;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    checks++;
    if (frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_ready got=%b exp=0", frame_ready);
    end
    enable = 1'b1;
    tick();
    k = 0;
    checks++;
    if (frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_swap_ready got=%b exp=1", frame_ready);
    end
    for (int i = 1; i <= 25; i++) begin
      tick();
      checks++;
      if (col_sel !== e_sel(k) || row_out !== e_row(k, fa)) begin
        errors++;
        $display("FAIL run_disp k=%0d got=%b/%h exp=%b/%h",
                 k, col_sel, row_out, e_sel(k), e_row(k, fa));
      end
      checks++;
      if (frame_done !== e_done(k) || col_idx !== e_col(k)) begin
        errors++;
        $display("FAIL run_done_col k=%0d got=%b/%0d exp=%b/%0d",
                 k, frame_done, col_idx, e_done(k), e_col(k));
      end
    end
  endtask

  task automatic test_wrap();
    int nd = 0;
    while (k < 50) begin
      tick();
      if (frame_done === 1'b1) nd++;
      checks++;
      if (col_idx !== e_col(k) || col_sel !== e_sel(k)) begin
        errors++;
        $display("FAIL wrap_col k=%0d got=%0d/%b exp=%0d/%b",
                 k, col_idx, col_sel, e_col(k), e_sel(k));
      end
    end
    checks++;
    if (nd != 1) begin
      errors++;
      $display("FAIL wrap_done_count got=%0d exp=1", nd);
    end
  endtask

  task automatic test_double_buffer();
    while (k < 57) tick();
    frame_data  = fb;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    checks++;
    if (frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL db_ready_drop got=%b exp=0", frame_ready);
    end
    while (k < 74) begin
      tick();
      checks++;
      if (row_out !== e_row(k, fa) || frame_ready !== 1'b0) begin
        errors++;
        $display("FAIL db_hold k=%0d got=%h/%b exp=%h/0",
                 k, row_out, frame_ready, e_row(k, fa));
      end
    end
    tick();
    checks++;
    if (frame_ready !== 1'b1 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL db_swap_edge got=%b/%b exp=1/1",
               frame_ready, frame_done);
    end
    while (k < 79) begin
      tick();
      checks++;
      if (row_out !== e_row(k, fb) || col_sel !== e_sel(k)) begin
        errors++;
        $display("FAIL db_new k=%0d got=%h/%b exp=%h/%b",
                 k, row_out, col_sel, e_row(k, fb), e_sel(k));
      end
    end
  endtask

  task automatic test_backpressure();
    tick();
    frame_data  = fd;
    frame_valid = 1'b1;
    tick();
    checks++;
    if (frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_d_accept got=%b exp=0", frame_ready);
    end
    frame_data = fc;
    while (k < 99) begin
      tick();
      checks++;
      if (frame_ready !== 1'b0 || row_out !== e_row(k, fb)) begin
        errors++;
        $display("FAIL bp_wait k=%0d got=%b/%h exp=0/%h",
                 k, frame_ready, row_out, e_row(k, fb));
      end
    end
    tick();
    checks++;
    if (frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_swap_ready got=%b exp=1", frame_ready);
    end
    tick();
    frame_valid = 1'b0;
    checks++;
    if (frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_c_accept got=%b exp=0", frame_ready);
    end
    while (k < 129) begin
      tick();
      checks++;
      if (k < 125 && row_out !== e_row(k, fd)) begin
        errors++;
        $display("FAIL bp_show_d k=%0d got=%h exp=%h",
                 k, row_out, e_row(k, fd));
      end else if (k >= 125 && row_out !== e_row(k, fc)) begin
        errors++;
        $display("FAIL bp_show_c k=%0d got=%h exp=%h",
                 k, row_out, e_row(k, fc));
      end
    end
  endtask

  task automatic test_stop();
    while (k < 137) tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (col_sel !== 5'b11011 || row_out !== fc[14 +: 7]) begin
        errors++;
        $display("FAIL stop_finish k=%0d got=%b/%h exp=11011/%h",
                 k, col_sel, row_out, fc[14 +: 7]);
      end
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (col_sel !== 5'b11111 || col_idx !== 3'd0 ||
          frame_done !== 1'b0 || row_out !== 7'h00) begin
        errors++;
        $display("FAIL stop_idle k=%0d got=%b/%0d/%b/%h exp=11111/0/0/00",
                 k, col_sel, col_idx, frame_done, row_out);
      end
      tick();
    end
    enable = 1'b1;
    tick();
    k = 0;
    tick();
    tick();
    checks++;
    if (col_sel !== 5'b11110 || row_out !== fc[6:0] ||
        col_idx !== 3'd0) begin
      errors++;
      $display("FAIL restart got=%b/%h/%0d exp=11110/%h/0",
               col_sel, row_out, col_idx, fc[6:0]);
    end
  endtask

  task automatic test_reset_mid();
    while (k < 12) tick();
    checks++;
    if (col_sel !== 5'b11011) begin
      errors++;
      $display("FAIL mid_pre got=%b exp=11011", col_sel);
    end
    #2 reset = 1'b1;
    enable = 1'b0;
    #1;
    checks++;
    if (col_sel !== 5'b11111 || row_out !== 7'h00 ||
        col_idx !== 3'd0 || frame_done !== 1'b0 ||
        frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got=%b/%h/%0d/%b/%b exp=11111/00/0/0/1",
               col_sel, row_out, col_idx, frame_done, frame_ready);
    end
    #1 reset = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < NC; c++) begin
      fa[c*NR +: NR] = 7'h01 << c;
      fb[c*NR +: NR] = 7'h7F;
      fc[c*NR +: NR] = 7'h10 | 7'(c);
      fd[c*NR +: NR] = 7'h40 >> c;
    end
    test_reset();
    test_load_run();
    test_wrap();
    test_double_buffer();
    test_backpressure();
    test_stop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
